// File: rtl/ttl_pkg.sv
// ttl_pkg: definitions shared by the 74x-series counter models.
// Holds the count-direction encoding and the wrap-point (TOP) helper used by
// ttl_sync_counter and intended for future counters in the same family.
package ttl_pkg;

    // Encoding of the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest counter the TOP helper can describe.
    localparam int unsigned TTL_MAX_WIDTH = 64;

    // Highest count value before wrap.
    // Binary mode: all ones for the given width.
    // Modulo mode: modulus - 1 (e.g. 9 for a decade counter).
    // The caller truncates the result to its own width.
    function automatic logic [TTL_MAX_WIDTH-1:0] counter_top(
        input int unsigned     width,
        input longint unsigned modulus,
        input bit              modulo_en
    );
        logic [TTL_MAX_WIDTH-1:0] full_scale;
        if (width >= TTL_MAX_WIDTH) begin
            full_scale = '1;
        end else begin
            full_scale = (64'd1 << width) - 64'd1;
        end
        if (modulo_en) begin
            return modulus - 64'd1;
        end
        return full_scale;
    endfunction

endpackage : ttl_pkg

// File: rtl/ttl_sync_counter.sv
// ttl_sync_counter: parametrised 74x163/74x191-style synchronous counter.
// Up/down counting, synchronous parallel load, P/T enables and a
// combinational ripple-carry output (rco) for cascading via rco -> ent.
// Priority at each rising clk edge: rst > load > count > hold.
// Optional feature macro: TTL_COUNTER_MODULO_EN -- when defined the counter
// wraps at MODULUS-1 instead of 2^WIDTH-1.
module ttl_sync_counter
    import ttl_pkg::*;
#(
    parameter int unsigned     WIDTH       = 4,
    parameter longint unsigned RESET_VALUE = 0,
    parameter longint unsigned MODULUS     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

`ifdef TTL_COUNTER_MODULO_EN
    localparam bit MODULO_EN = 1'b1;
`else
    localparam bit MODULO_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] TOP     = WIDTH'(counter_top(WIDTH, MODULUS, MODULO_EN));
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             count_en;

    // Both enables must be high to count; enp is the local enable, ent the cascade enable.
    assign count_en = enp & ent;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = d;
        end else if (count_en) begin
            if (up == DIR_UP) begin
                // '>=' rather than '==' so a loaded value above TOP still wraps to 0.
                q_next = (q >= TOP) ? ZERO : q + ONE;
            end else begin
                q_next = (q == ZERO) ? TOP : q - ONE;
            end
        end
    end

    // Count register with synchronous reset taking precedence over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            q <= RESET_Q;
        end else begin
            q <= q_next;
        end
    end

    // Terminal count for the current direction, gated by ent; independent of enp.
    always_comb begin
        rco = 1'b0;
        if (ent) begin
            rco = (up == DIR_UP) ? (q == TOP) : (q == ZERO);
        end
    end

endmodule : ttl_sync_counter

// File: tb/tb_ttl_sync_counter.sv
// tb_ttl_sync_counter: directed self-checking bench for ttl_sync_counter.
// A single 4-bit counter covers reset, load, count, hold and rco behaviour;
// a pair of 4-bit counters chained rco -> ent covers cascading.
module tb_ttl_sync_counter;

`ifdef TTL_COUNTER_MODULO_EN
    localparam logic [3:0] TOP_E  = 4'd9;
    localparam int         CASC_N = 99;
    localparam logic [7:0] CASC_E = 8'h99;
`else
    localparam logic [3:0] TOP_E  = 4'd15;
    localparam int         CASC_N = 255;
    localparam logic [7:0] CASC_E = 8'hFF;
`endif

    logic       clk = 1'b0;
    logic       rst, load, enp, ent, up;
    logic [3:0] d, q;
    logic       rco;

    logic       c_rst, c_enp;
    logic [3:0] c_q0, c_q1;
    logic       c_rco0, c_rco1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ttl_sync_counter #(.WIDTH(4), .RESET_VALUE(0), .MODULUS(10)) u_dut (
        .clk(clk), .rst(rst), .load(load), .d(d), .enp(enp), .ent(ent),
        .up(up), .q(q), .rco(rco)
    );

    ttl_sync_counter #(.WIDTH(4), .RESET_VALUE(0), .MODULUS(10)) u_c0 (
        .clk(clk), .rst(c_rst), .load(1'b0), .d(4'h0), .enp(c_enp), .ent(1'b1),
        .up(1'b1), .q(c_q0), .rco(c_rco0)
    );

    ttl_sync_counter #(.WIDTH(4), .RESET_VALUE(0), .MODULUS(10)) u_c1 (
        .clk(clk), .rst(c_rst), .load(1'b0), .d(4'h0), .enp(c_enp), .ent(c_rco0),
        .up(1'b1), .q(c_q1), .rco(c_rco1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset overrides a simultaneous load; rco gated off by ent=0.
        rst = 1'b1; load = 1'b1; d = 4'b0101; enp = 1'b0; ent = 1'b0; up = 1'b0;
        c_rst = 1'b1; c_enp = 1'b0;
        tick();
        rst = 1'b0; load = 1'b0; c_rst = 1'b0;
        check("reset_q", q, 4'h0);
        check("reset_rco_ent0", rco, 1'b0);

        // 2: count up to TOP, rco at TOP, then wrap to 0.
        up = 1'b1; enp = 1'b1; ent = 1'b1;
        for (int i = 1; i <= int'(TOP_E); i++) begin
            tick();
            check("up_count", q, i);
        end
        check("up_top_rco", rco, 1'b1);
        tick();
        check("up_wrap_q", q, 4'h0);
        check("up_wrap_rco", rco, 1'b0);

        // 3: load with enables low, reset beating load, load beating count.
        enp = 1'b0; ent = 1'b0; load = 1'b1; d = 4'b1010;
        tick();
        check("load_q", q, 4'b1010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_over_load", q, 4'h0);
        d = 4'h3; enp = 1'b1; ent = 1'b1; up = 1'b1;
        tick();
        load = 1'b0;
        check("load_over_count", q, 4'h3);

        // 4: down from 0 wraps to TOP; rco follows 'up' immediately.
        load = 1'b1; d = 4'h0; enp = 1'b0;
        tick();
        load = 1'b0; up = 1'b0; ent = 1'b1;
        #1;
        check("down_zero_rco", rco, 1'b1);
        enp = 1'b1;
        tick();
        check("down_wrap_q", q, TOP_E);
        check("down_wrap_rco", rco, 1'b0);
        up = 1'b1;
        #1;
        check("up_flip_rco", rco, 1'b1);

        // 5: hold when either enable is low; rco ignores enp.
        enp = 1'b0; load = 1'b1; d = 4'b0110;
        tick();
        load = 1'b0; enp = 1'b1; ent = 1'b0;
        tick();
        check("hold_ent0_q", q, 4'b0110);
        check("hold_ent0_rco", rco, 1'b0);
        enp = 1'b0; ent = 1'b1;
        tick();
        check("hold_enp0_q", q, 4'b0110);
        check("hold_enp0_rco", rco, 1'b0);
        load = 1'b1; d = TOP_E;
        tick();
        load = 1'b0;
        tick();
        check("hold_top_q", q, TOP_E);
        check("hold_top_rco_enp0", rco, 1'b1);
        enp = 1'b1; up = 1'b0;
        tick();
        check("down_step", q, TOP_E - 4'd1);

`ifdef TTL_COUNTER_MODULO_EN
        // Modulo mode: 9 -> 0 with rco at 9; out-of-range loads.
        enp = 1'b0; up = 1'b1; load = 1'b1; d = 4'b1001;
        tick();
        load = 1'b0;
        check("mod_top_rco", rco, 1'b1);
        enp = 1'b1;
        tick();
        check("mod_wrap_q", q, 4'h0);
        enp = 1'b0; load = 1'b1; d = 4'b1100;
        tick();
        load = 1'b0;
        check("mod_over_rco", rco, 1'b0);
        enp = 1'b1;
        tick();
        check("mod_over_up", q, 4'h0);
        enp = 1'b0; load = 1'b1; d = 4'b1100;
        tick();
        load = 1'b0; enp = 1'b1; up = 1'b0;
        tick();
        check("mod_over_down", q, 4'b1011);
`endif

        // 6: two-stage cascade, rco0 -> ent1, shared enp.
        enp = 1'b0;
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0;
        check("casc_reset", {c_q1, c_q0}, 8'h00);
        c_enp = 1'b1;
        for (int i = 0; i < CASC_N; i++) begin
            tick();
        end
        check("casc_full_q", {c_q1, c_q0}, CASC_E);
        check("casc_full_rco", c_rco1, 1'b1);
        tick();
        check("casc_wrap_q", {c_q1, c_q0}, 8'h00);
        check("casc_wrap_rco", c_rco1, 1'b0);
        c_enp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ttl_sync_counter
